// File: rtl/add_share_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | add_share_pkg: shared types and constants for the adder-share block.   |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
package add_share_pkg;
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LO   = 2'd1,
      HI   = 2'd2,
      RESP = 2'd3
   } state_e;

   localparam int   ADD_W   = 32;
   localparam logic REQ_PC  = 1'b0;
   localparam logic REQ_ALU = 1'b1;
endpackage
`default_nettype wire

// File: rtl/rr_arb2.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | rr_arb2: two-way round-robin arbiter; pointer moves on accept.         |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module rr_arb2
   import add_share_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] valid_i,
   input  logic       accept_i,
   output logic [1:0] grant_o
);
   logic ptr_q, ptr_d;

   always_comb begin
      grant_o = valid_i;
      if (valid_i == 2'b11) begin
         grant_o = ptr_q ? 2'b10 : 2'b01;
      end
   end

   // After a grant the pointer favours the requester that lost.
   always_comb begin
      ptr_d = ptr_q;
      if (accept_i && (grant_o != 2'b00)) begin
         ptr_d = ~grant_o[1];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ptr_q <= REQ_PC;
      end else begin
         ptr_q <= ptr_d;
      end
   end
endmodule
`default_nettype wire

// File: rtl/add_share_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | add_share_ctrl: shares one W-bit adder between two requesters, one or  |
// | two carry-chained beats. ADD_SHARE_SUB_EN enables subtraction.         |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module add_share_ctrl
   import add_share_pkg::*;
#(
   parameter int W = ADD_W
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           req_valid_0,
   output logic           req_ready_0,
   input  logic [2*W-1:0] req_a_0,
   input  logic [2*W-1:0] req_b_0,
   input  logic           req_wide_0,
   input  logic           req_sub_0,
   input  logic           req_valid_1,
   output logic           req_ready_1,
   input  logic [2*W-1:0] req_a_1,
   input  logic [2*W-1:0] req_b_1,
   input  logic           req_wide_1,
   input  logic           req_sub_1,
   output logic           rsp_valid,
   input  logic           rsp_ready,
   output logic           rsp_id,
   output logic [2*W-1:0] rsp_sum,
   output logic           rsp_cout,
   output logic [W-1:0]   add_in1,
   output logic [W-1:0]   add_in2,
   output logic           add_cin,
   input  logic [W-1:0]   add_out,
   input  logic           add_cout
);
   state_e         state_q, state_d;
   logic [2*W-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
   logic           wide_q, wide_d, id_q, id_d;
   logic           carry_q, carry_d, rsp_valid_q, rsp_valid_d;
   logic           sub_w;
   logic [1:0]     grant;
   logic           accept;
   logic [2*W-1:0] b_eff;

`ifdef ADD_SHARE_SUB_EN
   logic sub_q, sub_d;
   assign sub_w = sub_q;
`else
   logic unused_sub;
   assign sub_w      = 1'b0;
   assign unused_sub = req_sub_0 ^ req_sub_1;
`endif

   rr_arb2 u_arb (
      .clk      (clk),
      .rst_n    (rst_n),
      .valid_i  ({req_valid_1, req_valid_0}),
      .accept_i (accept),
      .grant_o  (grant)
   );

   assign accept      = (state_q == IDLE) && (grant != 2'b00);
   assign req_ready_0 = (state_q == IDLE) && grant[0];
   assign req_ready_1 = (state_q == IDLE) && grant[1];
   assign b_eff       = b_q ^ {(2*W){sub_w}};

   always_comb begin
      add_in1 = '0;
      add_in2 = '0;
      add_cin = 1'b0;
      case (state_q)
         LO: begin
            add_in1 = a_q[W-1:0];
            add_in2 = b_eff[W-1:0];
            add_cin = sub_w;
         end
         HI: begin
            add_in1 = a_q[2*W-1:W];
            add_in2 = b_eff[2*W-1:W];
            add_cin = carry_q;
         end
         default: ;
      endcase
   end

   always_comb begin
      state_d     = state_q;
      a_d         = a_q;
      b_d         = b_q;
      sum_d       = sum_q;
      wide_d      = wide_q;
      id_d        = id_q;
      carry_d     = carry_q;
      rsp_valid_d = rsp_valid_q;
`ifdef ADD_SHARE_SUB_EN
      sub_d       = sub_q;
`endif
      case (state_q)
         IDLE: begin
            if (accept) begin
               id_d    = grant[1];
               a_d     = grant[1] ? req_a_1    : req_a_0;
               b_d     = grant[1] ? req_b_1    : req_b_0;
               wide_d  = grant[1] ? req_wide_1 : req_wide_0;
`ifdef ADD_SHARE_SUB_EN
               sub_d   = grant[1] ? req_sub_1  : req_sub_0;
`endif
               state_d = LO;
            end
         end
         LO: begin
            // Upper half cleared here so narrow results read back zero-extended.
            sum_d       = {{W{1'b0}}, add_out};
            carry_d     = add_cout;
            state_d     = wide_q ? HI : RESP;
            rsp_valid_d = !wide_q;
         end
         HI: begin
            sum_d[2*W-1:W] = add_out;
            carry_d        = add_cout;
            state_d        = RESP;
            rsp_valid_d    = 1'b1;
         end
         RESP: begin
            if (rsp_ready) begin
               state_d     = IDLE;
               rsp_valid_d = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         a_q         <= '0;
         b_q         <= '0;
         sum_q       <= '0;
         wide_q      <= 1'b0;
         id_q        <= 1'b0;
         carry_q     <= 1'b0;
         rsp_valid_q <= 1'b0;
`ifdef ADD_SHARE_SUB_EN
         sub_q       <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         a_q         <= a_d;
         b_q         <= b_d;
         sum_q       <= sum_d;
         wide_q      <= wide_d;
         id_q        <= id_d;
         carry_q     <= carry_d;
         rsp_valid_q <= rsp_valid_d;
`ifdef ADD_SHARE_SUB_EN
         sub_q       <= sub_d;
`endif
      end
   end

   assign rsp_valid = rsp_valid_q;
   assign rsp_id    = id_q;
   assign rsp_sum   = sum_q;
   assign rsp_cout  = carry_q;
endmodule
`default_nettype wire
